// File: rtl/uart_tx_frame_arbiter_if.sv
// Bundles the requester handshake and the byte-transmitter strobe/busy
// signals shared by the frame arbiter and its environment.
interface uart_tx_frame_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic                  frame_active;
    logic [3:0]            grant_id;

    // Arbiter side: consumes requests and busy, drives grants and bytes.
    modport master (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_start,
        output tx_data,
        output frame_active,
        output grant_id
    );

    // Environment side: requesters plus the byte transmitter.
    modport slave (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_start,
        input  tx_data,
        input  frame_active,
        input  grant_id
    );
endinterface

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NUM_REQ
// word producers. Each granted 32-bit word goes out as a 6-byte frame:
// header {HDR_NIBBLE, id}, data bytes LSB-first, then an XOR checksum.
module uart_tx_frame_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter logic [3:0]  HDR_NIBBLE = 4'hA
) (
    input logic                     clk,
    input logic                     rst_n,
    uart_tx_frame_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitHi, StWaitLo} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT_ZERO = NUM_REQ'(1);

    state_t      state;
    logic [3:0]  rr_ptr;
    logic [2:0]  byte_idx;
    logic [7:0]  chk;
    logic [31:0] shadow;

    logic        found;
    logic [3:0]  sel;
    logic [7:0]  cur_byte;
    int          idx;

    // Pick the first valid requester after rr_ptr; scanning from the far end
    // lets the nearest hit overwrite earlier ones.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % int'(NUM_REQ);
            if (|(bus.req_valid & (ONE_HOT_ZERO << idx))) begin
                found = 1'b1;
                sel   = 4'(idx);
            end
        end
    end

    // Byte presented in LOAD for the current frame position.
    always_comb begin
        cur_byte = chk;
        case (byte_idx)
            3'd0:    cur_byte = {HDR_NIBBLE, bus.grant_id};
            3'd1:    cur_byte = shadow[7:0];
            3'd2:    cur_byte = shadow[15:8];
            3'd3:    cur_byte = shadow[23:16];
            3'd4:    cur_byte = shadow[31:24];
            default: cur_byte = chk;
        endcase
    end

    // Frame FSM with registered handshake and transmitter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            rr_ptr           <= 4'(NUM_REQ - 1);
            byte_idx         <= '0;
            chk              <= '0;
            shadow           <= '0;
            bus.req_ready    <= '0;
            bus.tx_start     <= 1'b0;
            bus.tx_data      <= '0;
            bus.frame_active <= 1'b0;
            bus.grant_id     <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            case (state)
                StIdle: begin
                    // The transmitter is not reset with us, so never grant
                    // while it may still be shifting an abandoned byte.
                    if (found && !bus.tx_busy) begin
                        bus.req_ready    <= ONE_HOT_ZERO << sel;
                        shadow           <= 32'(bus.req_data >> (32 * sel));
                        bus.grant_id     <= sel;
                        rr_ptr           <= sel;
                        byte_idx         <= '0;
                        chk              <= '0;
                        bus.frame_active <= 1'b1;
                        state            <= StLoad;
                    end
                end
                StLoad: begin
                    bus.tx_data  <= cur_byte;
                    bus.tx_start <= 1'b1;
                    chk          <= chk ^ cur_byte;
                    state        <= StWaitHi;
                end
                StWaitHi: begin
                    if (bus.tx_busy) begin
                        state <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx == 3'd5) begin
                            bus.frame_active <= 1'b0;
                            state            <= StIdle;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= StLoad;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter with a simple transmitter model
// that stays busy for 11 cycles after each start strobe.
module tb_uart_tx_frame_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy_force = 1'b0;
    int   busy_cnt = 0;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    bit start_pending = 1'b0;

    logic [7:0] byte_q[$];
    logic [3:0] grant_q[$];

    uart_tx_frame_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_frame_arbiter #(
        .NUM_REQ   (4),
        .HDR_NIBBLE(4'hA)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_busy = busy_force | (busy_cnt != 0);

    // Transmitter model: busy for 11 cycles after a start strobe.
    always @(posedge clk) begin
        if (bus.tx_start) busy_cnt <= 11;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Record bytes and grants; count start/busy and one-hot violations.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.tx_start) begin
                byte_q.push_back(bus.tx_data);
                if (bus.tx_busy) viol++;
                if (start_pending) viol++;
                start_pending = 1'b1;
            end
            if (bus.req_ready != '0) begin
                grant_q.push_back(bus.grant_id);
                if ($countones(bus.req_ready) != 1) viol++;
            end
        end
        if (bus.tx_busy) start_pending = 1'b0;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        byte_q.delete();
        grant_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!bus.frame_active) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
        total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%b want=0", bus.frame_active); end
        total++; if (bus.grant_id !== 4'h0) begin bad++; $display("FAIL reset_grant_id got=%h want=0", bus.grant_id); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        logic [7:0] exp[6];
        bit ok;
        // Checksum: A2^78=DA, ^56=8C, ^34=B8, ^12=AA.
        exp = '{8'hA2, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA};
        byte_q.delete();
        grant_q.delete();
        bus.req_data[95:64] = 32'h12345678;
        bus.req_valid = 4'b0100;
        wait_ready(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_grant_timeout got=none want=grant"); end
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", bus.req_ready); end
        total++; if (bus.grant_id !== 4'd2) begin bad++; $display("FAIL single_grant_id got=%0d want=2", bus.grant_id); end
        bus.req_valid = '0;
        wait_idle(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=busy want=idle"); end
        total++; if (byte_q.size() != 6) begin bad++; $display("FAIL single_byte_count got=%0d want=6", byte_q.size()); end
        for (int i = 0; i < 6 && i < byte_q.size(); i++) begin
            total++;
            if (byte_q[i] !== exp[i]) begin bad++; $display("FAIL single_byte%0d got=%h want=%h", i, byte_q[i], exp[i]); end
        end
        total++; if (grant_q.size() != 1) begin bad++; $display("FAIL single_ready_pulses got=%0d want=1", grant_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g[5];
        int grants;
        bit ok;
        exp_g = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        do_reset();
        for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = 32'hD0C0B0A0 + i;
        bus.req_valid = 4'b1111;
        grants = 0;
        for (int i = 0; i < 1000 && grants < 5; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) grants++;
        end
        bus.req_valid = '0;
        total++; if (grants != 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", grants); end
        wait_idle(300, ok);
        total++; if (byte_q.size() != 30) begin bad++; $display("FAIL rr_byte_count got=%0d want=30", byte_q.size()); end
        for (int f = 0; f < 5 && 6 * f + 1 < byte_q.size(); f++) begin
            total++;
            if (byte_q[6*f] !== {4'hA, exp_g[f]}) begin
                bad++; $display("FAIL rr_header%0d got=%h want=%h", f, byte_q[6*f], {4'hA, exp_g[f]});
            end
            total++;
            if (byte_q[6*f+1] !== 8'hA0 + 8'(exp_g[f])) begin
                bad++; $display("FAIL rr_data%0d got=%h want=%h", f, byte_q[6*f+1], 8'hA0 + 8'(exp_g[f]));
            end
        end
    endtask

    task automatic test_busy_protocol();
        int seen;
        bit ok;
        busy_force = 1'b1;
        do_reset();
        bus.req_data[31:0] = 32'h00000001;
        bus.req_valid = 4'b0001;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req_ready != '0 || bus.tx_start) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL busy_hold_activity got=%0d want=0", seen); end
        busy_force = 1'b0;
        wait_ready(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_release_grant got=none want=grant"); end
        bus.req_valid = '0;
        wait_idle(300, ok);
        total++; if (byte_q.size() != 6) begin bad++; $display("FAIL busy_byte_count got=%0d want=6", byte_q.size()); end
        total++; if (byte_q.size() > 0 && byte_q[0] !== 8'hA0) begin bad++; $display("FAIL busy_header got=%h want=a0", byte_q[0]); end
        total++; if (viol != 0) begin bad++; $display("FAIL busy_protocol_viol got=%0d want=0", viol); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp[6];
        bit ok;
        // Checksum: A1^0D=AC, ^F0=5C, ^FE=A2, ^CA=68.
        exp = '{8'hA1, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h68};
        do_reset();
        bus.req_data[63:32] = 32'hCAFEF00D;
        bus.req_valid = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (byte_q.size() >= 3) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL midrst_start_timeout got=%0d want=3", byte_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL midrst_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx_data got=%h want=00", bus.tx_data); end
        total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL midrst_frame_active got=%b want=0", bus.frame_active); end
        total++; if (bus.grant_id !== 4'h0) begin bad++; $display("FAIL midrst_grant_id got=%h want=0", bus.grant_id); end
        repeat (3) @(negedge clk);
        byte_q.delete();
        grant_q.delete();
        rst_n = 1'b1;
        wait_ready(40, ok);
        total++; if (!ok || bus.grant_id !== 4'd1) begin bad++; $display("FAIL midrst_regrant got=%0d want=1", bus.grant_id); end
        bus.req_valid = '0;
        wait_idle(300, ok);
        total++; if (byte_q.size() != 6) begin bad++; $display("FAIL midrst_byte_count got=%0d want=6", byte_q.size()); end
        for (int i = 0; i < 6 && i < byte_q.size(); i++) begin
            total++;
            if (byte_q[i] !== exp[i]) begin bad++; $display("FAIL midrst_byte%0d got=%h want=%h", i, byte_q[i], exp[i]); end
        end
    endtask

    task automatic test_withdrawn();
        bit ok;
        do_reset();
        bus.req_data[31:0]   = 32'h01020304;
        bus.req_data[127:96] = 32'h0A0B0C0D;
        bus.req_valid = 4'b0001;
        wait_ready(20, ok);
        bus.req_valid = '0;
        for (int i = 0; i < 200 && byte_q.size() < 2; i++) @(negedge clk);
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 200 && byte_q.size() < 4; i++) @(negedge clk);
        bus.req_valid = 4'b1000;
        wait_idle(300, ok);
        wait_ready(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL wd_second_grant got=none want=grant"); end
        bus.req_valid = '0;
        wait_idle(300, ok);
        total++; if (grant_q.size() != 2) begin bad++; $display("FAIL wd_grant_count got=%0d want=2", grant_q.size()); end
        total++; if (grant_q.size() > 1 && grant_q[1] !== 4'd3) begin bad++; $display("FAIL wd_next_grant got=%0d want=3", grant_q[1]); end
        total++; if (byte_q.size() > 6 && byte_q[6] !== 8'hA3) begin bad++; $display("FAIL wd_header got=%h want=a3", byte_q[6]); end
    endtask

    task automatic test_checksum_zero();
        logic [7:0] exp[6];
        bit ok;
        exp = '{8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        bus.req_data[31:0] = 32'h000000A0;
        bus.req_valid = 4'b0001;
        wait_ready(40, ok);
        bus.req_valid = '0;
        wait_idle(300, ok);
        total++; if (byte_q.size() != 6) begin bad++; $display("FAIL zero_byte_count got=%0d want=6", byte_q.size()); end
        for (int i = 0; i < 6 && i < byte_q.size(); i++) begin
            total++;
            if (byte_q[i] !== exp[i]) begin bad++; $display("FAIL zero_byte%0d got=%h want=%h", i, byte_q[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_busy_protocol();
        test_reset_mid_frame();
        test_withdrawn();
        test_checksum_zero();
        total++; if (viol != 0) begin bad++; $display("FAIL protocol_violations got=%0d want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
